// File: rtl/matrix_result_streamer.sv
// Walks result matrix R in RAM row-major and streams each byte over valid/ready.
// Optional MM_STREAM_HEADER_EN: prefix the stream with one header byte holding N.
module matrix_result_streamer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int N_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_WIDTH-1:0]    n_in,
    input  logic [ADDR_WIDTH-1:0] base_r,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_SEND,
`ifdef MM_STREAM_HEADER_EN
        S_HEADER,
`endif
        S_FINISH
    } state_t;

    localparam logic [N_WIDTH-1:0] N_ONE = 1;

    state_t                  state_q;
    state_t                  state_d;
    logic [N_WIDTH-1:0]      n_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [N_WIDTH-1:0]      r_q;
    logic [N_WIDTH-1:0]      c_q;
    logic [N_WIDTH-1:0]      n_last;
    logic                    accept;
    logic                    last_col;
    logic                    last_elem;
    logic [ADDR_WIDTH-1:0]   elem_addr;

    assign n_last    = n_q - N_ONE;
    assign accept    = data_valid && data_ready;
    assign last_col  = (c_q == n_last);
    assign last_elem = last_col && (r_q == n_last);
    assign elem_addr = base_q
                     + ADDR_WIDTH'(r_q) * ADDR_WIDTH'(n_q)
                     + ADDR_WIDTH'(c_q);

    assign mem_we = 1'b0;
    assign done   = (state_q == S_FINISH);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; the stream only advances on a completed handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef MM_STREAM_HEADER_EN
                    state_d = S_HEADER;
`else
                    state_d = (n_in == '0) ? S_FINISH : S_ISSUE;
`endif
                end
            end
`ifdef MM_STREAM_HEADER_EN
            S_HEADER: begin
                if (accept) begin
                    state_d = (n_q == '0) ? S_FINISH : S_ISSUE;
                end
            end
`endif
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SEND;
            S_SEND: begin
                if (accept) begin
                    state_d = last_elem ? S_FINISH : S_ISSUE;
                end
            end
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: job capture, address generation, output byte and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q        <= '0;
            base_q     <= '0;
            r_q        <= '0;
            c_q        <= '0;
            mem_addr   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q    <= n_in;
                        base_q <= base_r;
                        r_q    <= '0;
                        c_q    <= '0;
                        busy   <= 1'b1;
`ifdef MM_STREAM_HEADER_EN
                        data_out   <= DATA_WIDTH'(n_in);
                        data_valid <= 1'b1;
`endif
                    end
                end
`ifdef MM_STREAM_HEADER_EN
                S_HEADER: begin
                    if (accept) begin
                        data_valid <= 1'b0;
                    end
                end
`endif
                S_ISSUE: begin
                    mem_addr <= elem_addr;
                end
                S_CAPTURE: begin
                    data_out   <= mem_q;
                    data_valid <= 1'b1;
                end
                S_SEND: begin
                    if (accept) begin
                        data_valid <= 1'b0;
                        if (last_col) begin
                            c_q <= '0;
                            r_q <= r_q + N_ONE;
                        end else begin
                            c_q <= c_q + N_ONE;
                        end
                    end
                end
                S_FINISH: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: RAM model, byte-queue reference and timing rules.
// Honours MM_STREAM_HEADER_EN the same way the design does.
module tb_matrix_result_streamer;

`ifdef MM_STREAM_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] n_in;
    logic [9:0] base_r;
    logic [9:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_q;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       done;

    matrix_result_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_in       (n_in),
        .base_r     (base_r),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_q      (mem_q),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    always @(posedge clk) mem_q <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    logic [7:0] expq [$];
    logic [7:0] rx   [$];
    int done_cnt;
    int done_at;
    int first_v;
    int start_k;
    int stall_id = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data;

    // Compare process: every handshake is checked against the reference queue.
    always @(negedge clk) begin
        chk("mem_we", int'(mem_we), 0);
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(data_valid), 1);
                chk("hold_data", int'(data_out), int'(prev_data));
            end
            if (data_valid && first_v < 0) first_v = cyc;
            if (data_valid && data_ready) begin
                if (expq.size() > 0) chk("byte", int'(data_out), int'(expq.pop_front()));
                rx.push_back(data_out);
            end
            if (done) begin
                done_cnt++;
                done_at = cyc;
                chk("done_busy", int'(busy), 1);
                chk("done_valid", int'(data_valid), 0);
            end
            prev_stall = data_valid && !data_ready;
            prev_data  = data_out;
        end
    end

    // Consumer: ready high, except a 5-cycle stall on element 4 when requested.
    initial begin : ready_drv
        int handled;
        handled = 0;
        data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_id != handled && data_valid && rx.size() == 4 + HDR) begin
                handled = stall_id;
                data_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk("stall_data", int'(data_out), 54);
                chk("stall_valid", int'(data_valid), 1);
                data_ready = 1'b1;
            end
        end
    end

    task automatic do_start(input int n, input int b);
        @(posedge clk);
        #1;
        start  = 1'b1;
        n_in   = 3'(n);
        base_r = 10'(b);
        start_k = cyc + 1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        n_in   = 3'd7;
        base_r = 10'd5;
    endtask

    task automatic prep(input int n, input int b);
        expq.delete();
        rx.delete();
        done_cnt = 0;
        done_at  = -1;
        first_v  = -1;
`ifdef MM_STREAM_HEADER_EN
        expq.push_back(8'(n));
`endif
        for (int i = 0; i < n * n; i++) expq.push_back(mem[(b + i) % 1024]);
    endtask

    task automatic run(input int n, input int b, input bit stall, input bit second);
        int budget;
        int exp_first;
        int fv;
        prep(n, b);
        if (stall) stall_id++;
        do_start(n, b);
        if (second) begin
            repeat (5) @(posedge clk);
            #1;
            start  = 1'b1;
            n_in   = 3'd2;
            base_r = 10'd0;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        budget = 0;
        while (done_cnt == 0 && budget < 4 * n * n + 60) begin
            @(negedge clk);
            budget++;
        end
        repeat (6) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("done_time", done_at - start_k, HDR + 4 * n * n + (stall ? 5 : 0));
        exp_first = (n == 0 && HDR == 0) ? -1 : ((HDR != 0) ? 0 : 3);
        fv = (first_v < 0) ? -1 : first_v - start_k;
        chk("first_lat", fv, exp_first);
        chk("rx_count", rx.size(), n * n + HDR);
        chk("left_exp", expq.size(), 0);
        chk("busy_after", int'(busy), 0);
    endtask

    task automatic lit_check();
        logic [7:0] lit [9];
        lit = '{8'd15, 8'd18, 8'd21, 8'd42, 8'd54, 8'd66, 8'd69, 8'd90, 8'd111};
        for (int i = 0; i < 9; i++) begin
            if (HDR + i < rx.size()) chk("lit_byte", int'(rx[HDR + i]), int'(lit[i]));
            else chk("lit_byte", -1, int'(lit[i]));
        end
`ifdef MM_STREAM_HEADER_EN
        if (rx.size() > 0) chk("lit_header", int'(rx[0]), 3);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_data"}, int'(data_out), 0);
        chk({tag, "_valid"}, int'(data_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin : main
        int wait_n;
        reset  = 1'b0;
        start  = 1'b0;
        n_in   = '0;
        base_r = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 255);
        for (int i = 0; i < 9; i++) begin
            mem[i]     = 8'(i);
            mem[9 + i] = 8'(i);
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) s += int'(mem[r * 3 + k]) * int'(mem[9 + k * 3 + c]);
                mem[18 + r * 3 + c] = 8'(s);
            end

        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b1;
        repeat (2) @(posedge clk);

        run(3, 18, 1'b0, 1'b0);
        lit_check();

        run(3, 18, 1'b1, 1'b0);
        lit_check();

        run(0, 18, 1'b0, 1'b0);

        run(3, 18, 1'b0, 1'b1);
        lit_check();

        run(2, 0, 1'b0, 1'b0);
        run(3, 1020, 1'b0, 1'b0);

        prep(3, 18);
        do_start(3, 18);
        wait_n = 0;
        while (rx.size() < 3 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        chk("pre_reset_rx", int'(rx.size() >= 3), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        run(3, 18, 1'b0, 1'b0);
        lit_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
